// File: rtl/snake_pkg.sv
// ----------------------------------------------------------------------------
// snake_pkg
//   Shared types and default constants for the snake game datapath.
//   dir_t    : movement direction of the snake head
//   state_t  : game state sequenced by snake_step_sched
//   opposite : direction that would reverse the snake onto its own body
// ----------------------------------------------------------------------------
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam int DEF_FRAMES_PER_STEP = 8;
    localparam int DEF_GRID_W          = 40;
    localparam int DEF_GRID_H          = 30;
    localparam int DEF_XW              = 6;
    localparam int DEF_YW              = 5;
    localparam int DEF_LENW            = 8;
    localparam int DEF_INIT_LEN        = 3;

    // The encoding places opposite directions two apart, so a modulo-4 add
    // of two gives the reversal.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d + 2'd2);
    endfunction

endpackage

// File: rtl/step_timer.sv
// ----------------------------------------------------------------------------
// step_timer
//   Counts video frame pulses and flags the frame that completes a snake step.
//   clk, reset   : clock and synchronous active-high reset
//   run          : count frame_start pulses only while high
//   clear        : restart the count from zero
//   frame_start  : one-cycle pulse per video frame
//   tick         : combinational; high on the frame_start that completes a step,
//                  so the caller can register its step enable on the same edge
// ----------------------------------------------------------------------------
module step_timer #(
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    input  logic frame_start,
    output logic tick
);

    localparam int            CW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    logic [CW-1:0] frame_cnt;

    assign tick = run && frame_start && (frame_cnt == LAST);

    // Frame counter: advances on each counted frame and wraps to zero on the
    // step frame. When run is low the count simply holds, which is how a
    // paused game keeps its place within the current step.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            frame_cnt <= '0;
        end else if (run && frame_start) begin
            if (tick) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/snake_step_sched.sv
// ----------------------------------------------------------------------------
// snake_step_sched
//   Game-tick scheduler for the snake datapath. Issues a one-cycle step_en
//   every FRAMES_PER_STEP frames while running, buffers direction requests
//   (dropping 180-degree reversals), moves the head with wrap-around, reacts
//   to the collision/food result in the cycle after each step and sequences
//   IDLE/RUN/PAUSE/DEAD.
//   Inputs : clk, reset (sync, active-high), frame_start, start, pause,
//            dir_valid, dir_req[1:0], collision, ate
//   Outputs: step_en, grow, head_x[XW-1:0], head_y[YW-1:0], dir[1:0],
//            length[LENW-1:0], state[1:0]  (all registered)
// ----------------------------------------------------------------------------
module snake_step_sched import snake_pkg::*; #(
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int GRID_W          = DEF_GRID_W,
    parameter int GRID_H          = DEF_GRID_H,
    parameter int XW              = DEF_XW,
    parameter int YW              = DEF_YW,
    parameter int LENW            = DEF_LENW,
    parameter int INIT_LEN        = DEF_INIT_LEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_start,
    input  logic            start,
    input  logic            pause,
    input  logic            dir_valid,
    input  logic [1:0]      dir_req,
    input  logic            collision,
    input  logic            ate,
    output logic            step_en,
    output logic            grow,
    output logic [XW-1:0]   head_x,
    output logic [YW-1:0]   head_y,
    output logic [1:0]      dir,
    output logic [LENW-1:0] length,
    output logic [1:0]      state
);

    state_t state_q, state_d;
    dir_t   dir_q, pending_q;
    logic   run, clear, tick, reinit, req_ok, check_die, check_eat;

    // step_en is only ever raised from RUN, so it alone marks the check cycle.
    assign check_die = step_en && collision;
    assign check_eat = step_en && !collision && ate;
    // Pause and a fatal collision both beat a step landing in the same cycle.
    assign run       = (state_q == RUN) && !pause && !check_die;
    assign clear     = (state_q == IDLE) && start;
    assign reinit    = (state_q == DEAD) && start;
    assign req_ok    = dir_valid && (state_q != DEAD) &&
                       (dir_t'(dir_req) != opposite(dir_q));

    assign dir   = dir_q;
    assign state = state_q;

    step_timer #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .frame_start(frame_start),
        .tick       (tick)
    );

    function automatic logic [XW-1:0] next_x(input logic [XW-1:0] x, input dir_t d);
        if (d == RIGHT) return (x == XW'(GRID_W - 1)) ? '0 : x + XW'(1);
        if (d == LEFT)  return (x == '0) ? XW'(GRID_W - 1) : x - XW'(1);
        return x;
    endfunction

    function automatic logic [YW-1:0] next_y(input logic [YW-1:0] y, input dir_t d);
        if (d == DOWN) return (y == YW'(GRID_H - 1)) ? '0 : y + YW'(1);
        if (d == UP)   return (y == '0) ? YW'(GRID_H - 1) : y - YW'(1);
        return y;
    endfunction

    // Game state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In RUN a collision in the check cycle outranks a
    // pause request; start is only meaningful in IDLE/DEAD and pause only in
    // RUN/PAUSE, so a coincident pair resolves by whichever the state uses.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (check_die)  state_d = DEAD;
                else if (pause) state_d = PAUSE;
            end
            PAUSE:   if (pause) state_d = RUN;
            DEAD:    if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers. The step edge moves the head using the pending
    // direction as it stood before this edge, so a request arriving in the
    // same cycle only affects the following step. Restarting from DEAD puts
    // everything back to the power-up position.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_en   <= 1'b0;
            grow      <= 1'b0;
            head_x    <= XW'(GRID_W / 2);
            head_y    <= YW'(GRID_H / 2);
            dir_q     <= RIGHT;
            pending_q <= RIGHT;
            length    <= LENW'(INIT_LEN);
        end else begin
            step_en <= tick;
            grow    <= check_eat;
            if (reinit) begin
                head_x    <= XW'(GRID_W / 2);
                head_y    <= YW'(GRID_H / 2);
                dir_q     <= RIGHT;
                pending_q <= RIGHT;
                length    <= LENW'(INIT_LEN);
            end else begin
                if (tick) begin
                    head_x <= next_x(head_x, pending_q);
                    head_y <= next_y(head_y, pending_q);
                    dir_q  <= pending_q;
                end
                if (req_ok) begin
                    pending_q <= dir_t'(dir_req);
                end
                if (check_eat && (length != '1)) begin
                    length <= length + LENW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_step_sched.sv
// ----------------------------------------------------------------------------
// tb_snake_step_sched
//   Directed bench for snake_step_sched. A behavioural model predicts every
//   clock edge; each predicted step pushes the expected head/dir into a
//   scoreboard queue that is popped when the design raises step_en.
// ----------------------------------------------------------------------------
module tb_snake_step_sched;
    import snake_pkg::*;

    localparam int FPS = 8;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
        logic [1:0] d;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       collision = 1'b0;
    logic       ate = 1'b0;
    logic       step_en, grow;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [1:0] dir;
    logic [7:0] length;
    logic [1:0] state;

    int    compared = 0;
    int    mismatched = 0;
    int    n_steps = 0;
    int    mark;
    step_t sb_q[$];

    // model state
    int m_state = 0, m_cnt = 0, m_x = 20, m_y = 15, m_dir = 1, m_pend = 1, m_len = 3;
    bit m_step = 1'b0, m_grow = 1'b0;

    always #5 clk = ~clk;

    snake_step_sched dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .start      (start),
        .pause      (pause),
        .dir_valid  (dir_valid),
        .dir_req    (dir_req),
        .collision  (collision),
        .ate        (ate),
        .step_en    (step_en),
        .grow       (grow),
        .head_x     (head_x),
        .head_y     (head_y),
        .dir        (dir),
        .length     (length),
        .state      (state)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
            $error("[TB] %s differs from model", tag);
        end
    endtask

    // Predict the effect of the upcoming clock edge from the current inputs.
    task automatic model_edge();
        int    old_state, old_dir;
        bit    die;
        step_t s;
        if (reset) begin
            m_state = 0; m_cnt = 0; m_x = 20; m_y = 15; m_dir = 1; m_pend = 1;
            m_len = 3; m_step = 1'b0; m_grow = 1'b0;
            sb_q.delete();
            return;
        end
        old_state = m_state;
        old_dir   = m_dir;
        die       = m_step && collision;
        m_grow    = m_step && !collision && ate;
        if (m_grow && m_len < 255) m_len++;
        m_step = 1'b0;
        case (old_state)
            0: if (start) begin m_state = 1; m_cnt = 0; end
            1: begin
                if (die) m_state = 3;
                else if (pause) m_state = 2;
                else if (frame_start) begin
                    if (m_cnt == FPS - 1) begin
                        m_cnt  = 0;
                        m_step = 1'b1;
                        case (m_pend)
                            0: m_y = (m_y == 0)  ? 29 : m_y - 1;
                            1: m_x = (m_x == 39) ? 0  : m_x + 1;
                            2: m_y = (m_y == 29) ? 0  : m_y + 1;
                            default: m_x = (m_x == 0) ? 39 : m_x - 1;
                        endcase
                        m_dir = m_pend;
                        s.x = 6'(m_x);
                        s.y = 5'(m_y);
                        s.d = 2'(m_dir);
                        sb_q.push_back(s);
                    end else begin
                        m_cnt++;
                    end
                end
            end
            2: if (pause) m_state = 1;
            default: begin
                if (start) begin
                    m_state = 0; m_x = 20; m_y = 15; m_dir = 1; m_pend = 1; m_len = 3;
                end
            end
        endcase
        if (dir_valid && old_state != 3 && int'(dir_req) != (old_dir + 2) % 4)
            m_pend = int'(dir_req);
    endtask

    task automatic clock_edge();
        logic [11:0] exp_status;
        logic [12:0] exp_head;
        step_t       e;
        model_edge();
        @(posedge clk);
        #1;
        exp_status = {m_step, m_grow, 2'(m_state), 8'(m_len)};
        exp_head   = {6'(m_x), 5'(m_y), 2'(m_dir)};
        check_output("status", 32'({step_en, grow, state, length}), 32'(exp_status));
        check_output("head", 32'({head_x, head_y, dir}), 32'(exp_head));
        if (step_en === 1'b1) begin
            n_steps++;
            check_output("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_output("sb_head_x", 32'(head_x), 32'(e.x));
                check_output("sb_head_y", 32'(head_y), 32'(e.y));
                check_output("sb_dir", 32'(dir), 32'(e.d));
            end
        end else if (m_step && sb_q.size() != 0) begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic apply_stimulus(input bit fs, input bit st, input bit ps, input bit dv,
                                  input logic [1:0] dr, input bit col, input bit at);
        frame_start = fs; start = st; pause = ps; dir_valid = dv;
        dir_req = dr; collision = col; ate = at;
        clock_edge();
        frame_start = 1'b0; start = 1'b0; pause = 1'b0; dir_valid = 1'b0;
        dir_req = 2'd0; collision = 1'b0; ate = 1'b0;
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic request(input logic [1:0] dr);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, dr, 1'b0, 1'b0);
    endtask

    // Each frame is a frame_start cycle followed by a gap cycle; the gap
    // after a step is the check cycle, where col/at are presented.
    task automatic frames(input int n, input bit col, input bit at);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, col, at);
        end
    endtask

    initial begin
        $display("[TB] starting snake_step_sched bench");

        // 1: reset values, then two steps over 16 frames
        reset = 1'b1;
        idle_cycle();
        idle_cycle();
        reset = 1'b0;
        check_output("rst_state", 32'(state), 32'(IDLE));
        check_output("rst_head_x", 32'(head_x), 32'd20);
        check_output("rst_head_y", 32'(head_y), 32'd15);
        check_output("rst_dir", 32'(dir), 32'(RIGHT));
        check_output("rst_length", 32'(length), 32'd3);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);   // pause ignored in IDLE
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);   // start
        check_output("run_state", 32'(state), 32'(RUN));
        mark = n_steps;
        frames(16, 1'b0, 1'b0);
        check_output("two_steps", 32'(n_steps - mark), 32'd2);
        check_output("t1_head_x", 32'(head_x), 32'd22);

        // 2: wrap-around on every edge
        frames(17 * FPS, 1'b0, 1'b0);
        check_output("x_at_39", 32'(head_x), 32'd39);
        frames(FPS, 1'b0, 1'b0);
        check_output("wrap_right", 32'(head_x), 32'd0);
        request(UP);
        frames(15 * FPS, 1'b0, 1'b0);
        check_output("y_at_0", 32'(head_y), 32'd0);
        frames(FPS, 1'b0, 1'b0);
        check_output("wrap_up", 32'(head_y), 32'd29);
        request(LEFT);
        frames(FPS, 1'b0, 1'b0);
        check_output("wrap_left", 32'(head_x), 32'd39);

        // 3: reversal rejection and last-request-wins
        request(UP);
        frames(FPS, 1'b0, 1'b0);
        request(RIGHT);
        frames(FPS, 1'b0, 1'b0);
        check_output("dir_right", 32'(dir), 32'(RIGHT));
        request(LEFT);
        frames(FPS, 1'b0, 1'b0);
        check_output("reversal_dropped", 32'(dir), 32'(RIGHT));
        check_output("reversal_x", 32'(head_x), 32'd1);
        request(UP);
        request(DOWN);
        frames(FPS, 1'b0, 1'b0);
        check_output("last_wins_down", 32'(dir), 32'(DOWN));
        check_output("last_wins_y", 32'(head_y), 32'd29);
        request(LEFT);
        request(RIGHT);
        frames(FPS, 1'b0, 1'b0);
        check_output("last_wins_right", 32'(dir), 32'(RIGHT));
        frames(FPS - 1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, UP, 1'b0, 1'b0);     // request on step edge
        check_output("same_cycle_req", 32'(dir), 32'(RIGHT));
        idle_cycle();
        frames(FPS, 1'b0, 1'b0);
        check_output("next_step_up", 32'(dir), 32'(UP));

        // 4: collision kills the game, restart returns to IDLE
        frames(FPS, 1'b1, 1'b1);
        check_output("dead_state", 32'(state), 32'(DEAD));
        check_output("dead_no_grow", 32'(grow), 32'd0);
        mark = n_steps;
        frames(20, 1'b0, 1'b0);
        check_output("dead_no_steps", 32'(n_steps - mark), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check_output("restart_state", 32'(state), 32'(IDLE));
        check_output("restart_x", 32'(head_x), 32'd20);
        check_output("restart_y", 32'(head_y), 32'd15);
        check_output("restart_len", 32'(length), 32'd3);

        // 5: growth and saturation
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        frames(FPS, 1'b0, 1'b1);
        check_output("grow_pulse", 32'(grow), 32'd1);
        check_output("len_4", 32'(length), 32'd4);
        idle_cycle();
        check_output("grow_one_cycle", 32'(grow), 32'd0);
        frames(251 * FPS, 1'b0, 1'b1);
        check_output("len_255", 32'(length), 32'd255);
        frames(FPS, 1'b0, 1'b1);
        check_output("sat_grow", 32'(grow), 32'd1);
        check_output("sat_len", 32'(length), 32'd255);

        // 6: pause priority, resume, reset during a step
        frames(FPS - 1, 1'b0, 1'b0);
        mark = n_steps;
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check_output("pause_state", 32'(state), 32'(PAUSE));
        check_output("pause_no_step", 32'(step_en), 32'd0);
        frames(FPS, 1'b0, 1'b0);
        check_output("paused_no_steps", 32'(n_steps - mark), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check_output("resume_state", 32'(state), 32'(RUN));
        mark = n_steps;
        frames(FPS, 1'b0, 1'b0);
        check_output("resume_one_step", 32'(n_steps - mark), 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, UP, 1'b0, 1'b0);
        check_output("step_before_reset", 32'(step_en), 32'd1);
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        check_output("mid_rst_step", 32'(step_en), 32'd0);
        check_output("mid_rst_grow", 32'(grow), 32'd0);
        check_output("mid_rst_state", 32'(state), 32'(IDLE));
        check_output("mid_rst_head", 32'({head_x, head_y}), 32'({6'd20, 5'd15}));
        check_output("mid_rst_len", 32'(length), 32'd3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        frames(FPS, 1'b0, 1'b0);
        check_output("pending_discarded_x", 32'(head_x), 32'd21);
        check_output("pending_discarded_dir", 32'(dir), 32'(RIGHT));

        check_output("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
